// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller: steps the shared datapath through
// fetch/decode/execute/mem/writeback for R-type, OP-IMM, LOAD and STORE.
//
// state     | meaning
// FETCH     | imem_req held until imem_ack; IR loaded on the ack cycle
// DECODE    | IR stable; legal opcodes go to EXECUTE, anything else to HALT
// EXECUTE   | ALU operation and operand select presented
// MEM       | LOAD/STORE access held until dmem_ack; STORE retires here
// WRITEBACK | register write, PC advance and retire, one cycle
// HALT      | illegal instruction seen; left only through rst_n
module multicycle_ctrl #(
  parameter int ALU_CTRL_WIDTH    = 4,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INSTRUCTION_WIDTH-1:0] inst,
  input  logic                         imem_ack,
  input  logic                         dmem_ack,
  output logic                         imem_req,
  output logic                         ir_wr_en,
  output logic                         pc_wr_en,
  output logic [ALU_CTRL_WIDTH-1:0]    alu_ctrl,
  output logic                         alu_op2_sel,
  output logic                         reg_file_wr_en,
  output logic                         reg_file_wr_back_sel,
  output logic                         data_mem_rd_en,
  output logic                         data_mem_wr_en,
  output logic                         inst_retired,
  output logic                         illegal_inst
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [2:0] state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_ld, is_st, is_legal;
  logic [3:0] alu_op;
  logic       unused_inst_bits;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_r     = (opcode == OPC_R);
  assign is_i     = (opcode == OPC_OP_IMM);
  assign is_ld    = (opcode == OPC_LOAD);
  assign is_st    = (opcode == OPC_STORE);
  assign is_legal = is_r | is_i | is_ld | is_st;

  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

  // inst[30] only selects SUB/SRA; for OP-IMM it is part of the immediate
  // except on the shift-right encoding.
  always_comb begin
    alu_op = 4'b0000;
    if (is_r)      alu_op = {inst[30], funct3};
    else if (is_i) alu_op = {(funct3 == 3'b101) & inst[30], funct3};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (imem_ack) state_d = S_DECODE;
      S_DECODE:    state_d = is_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE:   state_d = (is_ld | is_st) ? S_MEM : S_WRITEBACK;
      S_MEM:       if (dmem_ack) state_d = is_st ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Outputs are forced low while rst_n is asserted, even though the state
  // register already reads FETCH.
  always_comb begin
    imem_req             = 1'b0;
    ir_wr_en             = 1'b0;
    pc_wr_en             = 1'b0;
    alu_ctrl             = '0;
    alu_op2_sel          = 1'b0;
    reg_file_wr_en       = 1'b0;
    reg_file_wr_back_sel = 1'b0;
    data_mem_rd_en       = 1'b0;
    data_mem_wr_en       = 1'b0;
    inst_retired         = 1'b0;
    illegal_inst         = 1'b0;
    if (rst_n) begin
      if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WRITEBACK) begin
        alu_ctrl    = ALU_CTRL_WIDTH'(alu_op);
        alu_op2_sel = ~is_r;
      end
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_wr_en = imem_ack;
        end
        S_MEM: begin
          data_mem_rd_en = is_ld;
          data_mem_wr_en = is_st;
          pc_wr_en       = is_st & dmem_ack;
          inst_retired   = is_st & dmem_ack;
        end
        S_WRITEBACK: begin
          reg_file_wr_en       = 1'b1;
          pc_wr_en             = 1'b1;
          inst_retired         = 1'b1;
          reg_file_wr_back_sel = is_r | is_i;
        end
        S_HALT:  illegal_inst = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction cycle schedule is
// built from the instruction class and ack delays, then compared every cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        imem_ack, dmem_ack;
  logic        imem_req, ir_wr_en, pc_wr_en;
  logic [3:0]  alu_ctrl;
  logic        alu_op2_sel, reg_file_wr_en, reg_file_wr_back_sel;
  logic        data_mem_rd_en, data_mem_wr_en, inst_retired, illegal_inst;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.ALU_CTRL_WIDTH(4), .INSTRUCTION_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_wr_en(ir_wr_en), .pc_wr_en(pc_wr_en), .alu_ctrl(alu_ctrl),
    .alu_op2_sel(alu_op2_sel), .reg_file_wr_en(reg_file_wr_en),
    .reg_file_wr_back_sel(reg_file_wr_back_sel), .data_mem_rd_en(data_mem_rd_en),
    .data_mem_wr_en(data_mem_wr_en), .inst_retired(inst_retired), .illegal_inst(illegal_inst)
  );

  always #5 clk = ~clk;

  // Vector layout: {imem_req, ir_wr_en, pc_wr_en, alu_ctrl[3:0], op2_sel,
  //                 rf_wr_en, wr_back_sel, rd_en, wr_en, retired, illegal}
  localparam logic [13:0] FULL    = 14'h3fff;
  localparam logic [13:0] M_ALU   = 14'b00_0_1111_1_0_0_0_0_0_0;
  localparam logic [13:0] M_WBSEL = 14'b00_0_0000_0_0_1_0_0_0_0;
  localparam logic [13:0] M_OP2   = 14'b00_0_0000_1_0_0_0_0_0_0;

  logic [13:0] exp_q[$];
  logic [13:0] mask_q[$];
  bit          imem_q[$];
  bit          dmem_q[$];
  bit          fetch_q[$];
  logic [31:0] cur_inst;

  function automatic logic [13:0] pack_out();
    return {imem_req, ir_wr_en, pc_wr_en, alu_ctrl, alu_op2_sel, reg_file_wr_en,
            reg_file_wr_back_sel, data_mem_rd_en, data_mem_wr_en, inst_retired, illegal_inst};
  endfunction

  // 0 = R, 1 = OP-IMM, 2 = LOAD, 3 = STORE, -1 = illegal
  function automatic int kind_of(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] i);
    int k;
    logic [2:0] f3;
    k  = kind_of(i);
    f3 = i[14:12];
    if (k == 0) return {i[30], f3};
    if (k == 1) return {(f3 == 3'd5) ? i[30] : 1'b0, f3};
    return 4'd0;
  endfunction

  task automatic push(input logic [13:0] v, input logic [13:0] m, input bit ia, input bit da,
                      input bit f);
    exp_q.push_back(v); mask_q.push_back(m);
    imem_q.push_back(ia); dmem_q.push_back(da); fetch_q.push_back(f);
  endtask

  // Build the expected per-cycle schedule for one instruction.
  task automatic build(input logic [31:0] ins, input int iw, input int dw, input int halt_n);
    int k;
    logic [13:0] v;
    logic [3:0] a;
    exp_q.delete(); mask_q.delete(); imem_q.delete(); dmem_q.delete(); fetch_q.delete();
    cur_inst = ins;
    k = kind_of(ins);
    a = ref_alu(ins);
    for (int c = 0; c <= iw; c++) begin
      v = '0; v[13] = 1'b1; v[12] = (c == iw);
      push(v, FULL & ~M_ALU & ~M_WBSEL, c == iw, 1'($urandom), 1'b1);
    end
    push(14'd0, FULL & ~M_ALU & ~M_WBSEL, 1'($urandom), 1'($urandom), 1'b0);
    if (k < 0) begin
      for (int c = 0; c < halt_n; c++) push(14'd1, FULL, 1'($urandom), 1'($urandom), 1'b0);
      return;
    end
    v = '0; v[10:7] = a; v[6] = (k != 0);
    push(v, FULL & ~M_WBSEL, 1'($urandom), 1'($urandom), 1'b0);
    if (k >= 2) begin
      for (int c = 0; c <= dw; c++) begin
        v = '0; v[10:7] = a; v[6] = 1'b1;
        v[3] = (k == 2); v[2] = (k == 3);
        v[11] = (k == 3) && (c == dw); v[1] = (k == 3) && (c == dw);
        push(v, FULL & ~M_WBSEL, 1'($urandom), c == dw, 1'b0);
      end
    end
    if (k != 3) begin
      v = '0; v[10:7] = a; v[5] = 1'b1; v[11] = 1'b1; v[1] = 1'b1; v[4] = (k < 2);
      push(v, FULL & ~M_OP2, 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  // Starts and ends at posedge+1. abort_at >= 0 asserts rst_n after that cycle's check.
  task automatic run(input string name, input int abort_at);
    logic [13:0] got;
    for (int i = 0; i < exp_q.size(); i++) begin
      imem_ack = imem_q[i];
      dmem_ack = dmem_q[i];
      inst     = fetch_q[i] ? 32'($urandom) : cur_inst;
      #2;
      got = pack_out();
      checks++;
      if ((got & mask_q[i]) !== (exp_q[i] & mask_q[i])) begin
        errors++;
        $display("FAIL %s cycle=%0d inst=%h got=%h exp=%h mask=%h", name, i, cur_inst, got,
                 exp_q[i], mask_q[i]);
      end
      if (i == abort_at) begin
        rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        checks++;
        if (pack_out() !== 14'd0) begin
          errors++;
          $display("FAIL %s_async_reset got=%h exp=0", name, pack_out());
        end
        repeat (2) begin
          @(posedge clk); #2;
          checks++;
          if (pack_out() !== 14'd0) begin
            errors++;
            $display("FAIL %s_in_reset got=%h exp=0", name, pack_out());
          end
        end
        @(posedge clk); #1;
        imem_ack = 1'b0; dmem_ack = 1'b0; rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_pulse(input string name);
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++;
    if (pack_out() !== 14'd0) begin
      errors++;
      $display("FAIL %s_reset_low got=%h exp=0", name, pack_out());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({imem_req, ir_wr_en, illegal_inst} !== 3'b100) begin
      errors++;
      $display("FAIL %s_refetch got=%b exp=100", name, {imem_req, ir_wr_en, illegal_inst});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1; inst = 32'($urandom);
    #3;
    checks++;
    if (pack_out() !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", pack_out());
    end
    @(posedge clk); #1;
    checks++;
    if (pack_out() !== 14'd0) begin
      errors++;
      $display("FAIL reset_held got=%h exp=0", pack_out());
    end
    @(posedge clk); #1;
    imem_ack = 1'b0; dmem_ack = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    build(32'h002081B3, 0, 0, 0); run("r_add", -1);
    build(32'h402081B3, 0, 0, 0); run("r_sub", -1);
  endtask

  task automatic test_load_wait();
    build(32'h0040A183, 0, 3, 0); run("load_wait3", -1);
  endtask

  task automatic test_store();
    build(32'h0020A223, 0, 0, 0); run("store", -1);
  endtask

  task automatic test_opimm();
    build(32'h4030D193, 0, 0, 0); run("srai", -1);
    build(32'h40008193, 0, 0, 0); run("addi_b30", -1);
  endtask

  task automatic test_illegal();
    build(32'h00000000, 0, 0, 20); run("illegal_zero", -1);
    reset_pulse("illegal_zero");
    build(32'h00000063, 1, 0, 20); run("illegal_branch", -1);
    reset_pulse("illegal_branch");
  endtask

  task automatic test_reset_mid_mem();
    build(32'h0040A183, 0, 4, 0); run("mid_mem", 4);
    build(32'h002081B3, 5, 0, 0); run("fetch_wait5", -1);
  endtask

  task automatic test_random();
    logic [31:0] ri;
    int sel;
    for (int n = 0; n < 60; n++) begin
      ri  = 32'($urandom);
      sel = int'($urandom_range(0, 8));
      case (sel)
        0, 1:    ri[6:0] = 7'b0110011;
        2, 3:    ri[6:0] = 7'b0010011;
        4, 5:    ri[6:0] = 7'b0000011;
        6, 7:    ri[6:0] = 7'b0100011;
        default: if (kind_of(ri) >= 0) ri[1:0] = 2'b01;
      endcase
      build(ri, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3);
      run("random", -1);
      if (kind_of(ri) < 0) reset_pulse("random_illegal");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_opimm();
    test_illegal();
    test_reset_mid_mem();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencing controller for the multi-cycle RV32I core.
- Steps the shared datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK: one instruction memory port, one data memory port, one ALU, register file and an external instruction register (IR).
- Supports R-type, OP-IMM, LOAD and STORE. Halts on an illegal instruction.
- Sits between the IR and the datapath. Drives the same ALU/register-file/data-memory control encoding as the single-cycle decoder, plus the sequencing strobes.

Parameters:
- ALU_CTRL_WIDTH, 4, width of alu_ctrl.
- INSTRUCTION_WIDTH, 32, width of inst.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst  input  32  IR contents; valid from DECODE onward.
- imem_ack  input  1  instruction memory has returned rdata this cycle.
- dmem_ack  input  1  data memory access completes this cycle.
- imem_req  output  1  instruction fetch request.
- ir_wr_en  output  1  load IR from imem rdata.
- pc_wr_en  output  1  PC <= PC+4.
- alu_ctrl  output  4  {mod, funct3} ALU operation.
- alu_op2_sel  output  1  0 = rs2, 1 = immediate.
- reg_file_wr_en  output  1  register file write strobe.
- reg_file_wr_back_sel  output  1  1 = ALU result, 0 = load data.
- data_mem_rd_en  output  1  data memory read request.
- data_mem_wr_en  output  1  data memory write request.
- inst_retired  output  1  one-cycle pulse per completed instruction.
- illegal_inst  output  1  level; high while in HALT.

Behaviour:
- State register: 3 bits, states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. Outputs are decoded combinationally from the state and inst only, with no input-to-output paths except as listed below.
- Reset (rst_n low, asynchronous): state = FETCH. During reset all outputs = 0, including imem_req. Reset mid-instruction abandons it; no PC or register-file write occurs.
- FETCH:
  - imem_req = 1, held until imem_ack. Same-cycle ack is legal.
  - ir_wr_en = imem_ack (combinational).
  - On ack, go to DECODE; otherwise stay.
- DECODE:
  - Legal means inst[1:0] == 2'b11 and inst[6:2] is one of 01100 (R), 00100 (OP-IMM), 00000 (LOAD), 01000 (STORE).
  - Legal: go to EXECUTE.
  - Illegal: go to HALT.
  - All strobes 0.
- EXECUTE: alu_ctrl and alu_op2_sel are valid. Routing:
  - R: alu_ctrl = {inst[30], inst[14:12]}, op2_sel = 0, next WRITEBACK.
  - OP-IMM: alu_ctrl = {(inst[14:12]==3'b101) ? inst[30] : 1'b0, inst[14:12]}, op2_sel = 1, next WRITEBACK.
  - LOAD/STORE: alu_ctrl = 4'b0000 (ADD), op2_sel = 1, next MEM.
- MEM:
  - LOAD: data_mem_rd_en = 1, held until dmem_ack, then go to WRITEBACK.
  - STORE: data_mem_wr_en = 1, held until dmem_ack.
  - On STORE ack, in the same cycle: pc_wr_en = 1 and inst_retired = 1, then go to FETCH.
  - alu_ctrl and op2_sel keep their EXECUTE values throughout MEM.
- WRITEBACK:
  - reg_file_wr_en = 1, pc_wr_en = 1, inst_retired = 1, each for exactly one cycle, then go to FETCH.
  - wr_back_sel = 1 for R/OP-IMM, 0 for LOAD.
  - alu_ctrl is held.
- HALT:
  - illegal_inst = 1. All other outputs 0.
  - The only exit is rst_n. No PC advance, no write.
- Latency with zero-wait memory (ack in the first cycle): R/OP-IMM 4 cycles, STORE 4 cycles, LOAD 5 cycles. Each wait cycle of imem_ack or dmem_ack adds one cycle.
- Invariants:
  - data_mem_rd_en and data_mem_wr_en are never both 1.
  - pc_wr_en and inst_retired are never high on consecutive cycles.
  - reg_file_wr_en is never 1 outside WRITEBACK.
  - inst is sampled only in DECODE through MEM/WRITEBACK, and is stable there because ir_wr_en is low.
- Spurious acks: imem_ack outside FETCH and dmem_ack outside MEM are ignored.

Test Plan:
1. Reset, then R-type ADD 0x002081B3 with immediate acks: FETCH→DECODE→EXECUTE→WRITEBACK. alu_ctrl = 4'b0000, op2_sel = 0, reg_file_wr_en = pc_wr_en = inst_retired = 1 in cycle 4. Repeat with SUB 0x402081B3: alu_ctrl = 4'b1000.
2. LOAD 0x0040A183 with dmem_ack delayed 3 cycles: data_mem_rd_en high for 4 cycles, wr_back_sel = 0 in WRITEBACK, total 8 cycles, one inst_retired.
3. STORE 0x0020A223 with immediate dmem_ack: data_mem_wr_en = 1, and pc_wr_en = inst_retired = 1 in the same MEM cycle. reg_file_wr_en never asserted. 4 cycles.
4. SRAI 0x4030D193: alu_ctrl = 4'b1101, op2_sel = 1. ADDI with inst[30] = 1 (0x4000_8193): alu_ctrl = 4'b0000.
5. Illegal inst 0x00000000 and opcode 1100011 (branch): HALT, illegal_inst = 1 steady for 20 cycles, no strobes. rst_n pulse returns to FETCH with imem_req = 1.
6. Assert rst_n low asynchronously mid-MEM with data_mem_rd_en high: all outputs drop immediately, no pc_wr_en or reg_file_wr_en. After release, FETCH restarts; imem_ack withheld 5 cycles keeps imem_req high and ir_wr_en low throughout.
